fetch_queue: RTL and testbench

Instruction prefetch unit between the instruction memory and the RV32 IF/ID pipe register. It issues in-order word fetches with a request/grant handshake and absorbs variable memory latency in a DEPTH-entry {pc, instr} queue. It hands instructions to the core with a valid/ready handshake. On a taken branch or jump redirect from EX it flushes the queue and discards in-flight responses.

---
 rtl/fetch_queue.sv | 131 +++++++++++++
 tb/tb_fetch_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction prefetch unit sitting between instruction memory and the
// IF/ID pipe register. Issues in-order word fetches with a req/gnt handshake,
// buffers up to DEPTH {pc, instr} entries to absorb memory latency, and hands
// instructions to the core over a valid/ready handshake. A redirect from EX
// flushes the queue; responses still in flight at that point are discarded.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   imem_req/addr   fetch request and word-aligned fetch address
//   imem_gnt        memory accepts the current request
//   imem_rvalid     response valid (in grant order)
//   imem_rdata      response instruction word
//   instr_valid     queue head holds a filled entry
//   instr/instr_pc  head instruction / PC (NOP / 0 when not valid)
//   instr_ready     core accepts the head entry
//   redirect        taken branch or jump in EX
//   redirect_pc     new fetch target (low two bits ignored)
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]    fetch_pc;
    logic [31:0]    q_pc    [DEPTH];
    logic [31:0]    q_instr [DEPTH];
    logic [DEPTH-1:0] q_filled;

    logic [PW-1:0]  alloc_ptr;
    logic [PW-1:0]  fill_ptr;
    logic [PW-1:0]  head_ptr;
    logic [CW-1:0]  used;
    logic [CW-1:0]  discard;
    // Granted slots still waiting for their (non-discarded) response.
    logic [CW-1:0]  pend;

    logic grant;
    logic resp_keep;
    logic pop;
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        imem_req    = rst & ~redirect & (used < CW'(DEPTH)) & (discard == '0);
        imem_addr   = fetch_pc;
        grant       = imem_req & imem_gnt;
        resp_keep   = imem_rvalid & (discard == '0) & ~redirect;
        instr_valid = q_filled[head_ptr];
        pop         = instr_valid & instr_ready & ~redirect;
        instr       = instr_valid ? q_instr[head_ptr] : NOP;
        instr_pc    = instr_valid ? q_pc[head_ptr]    : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc  <= RESET_PC;
            q_filled  <= '0;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            used      <= '0;
            discard   <= '0;
            pend      <= '0;
        end else if (redirect) begin
            fetch_pc  <= {redirect_pc[31:2], 2'b00};
            q_filled  <= '0;
            fill_ptr  <= alloc_ptr;
            head_ptr  <= alloc_ptr;
            used      <= '0;
            pend      <= '0;
            // Everything outstanding becomes discardable; a response landing
            // this cycle is one of them (already discarded or pending) and is
            // dropped, so it is subtracted once either way.
            discard   <= discard + pend - CW'(imem_rvalid);
        end else begin
            if (grant) begin
                fetch_pc            <= fetch_pc + 32'd4;
                alloc_ptr           <= alloc_ptr + 1'b1;
                q_filled[alloc_ptr] <= 1'b0;
            end
            if (imem_rvalid && discard != '0) begin
                discard <= discard - 1'b1;
            end
            if (resp_keep) begin
                q_filled[fill_ptr] <= 1'b1;
                fill_ptr           <= fill_ptr + 1'b1;
            end
            // Clearing on pop keeps a stale filled bit from reappearing when
            // the head wraps onto a slot not yet re-granted.
            if (pop) begin
                q_filled[head_ptr] <= 1'b0;
                head_ptr           <= head_ptr + 1'b1;
            end
            used <= used + CW'(grant) - CW'(pop);
            pend <= pend + CW'(grant) - CW'(resp_keep);
        end
    end

    // Payload storage needs no reset: outputs are masked by the filled bits.
    always_ff @(posedge clk) begin
        if (grant) begin
            q_pc[alloc_ptr] <= fetch_pc;
        end
        if (resp_keep) begin
            q_instr[fill_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          INF      = 32'h7fff_ffff;
    localparam int          NCYC     = 3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected instruction stream: one entry per grant since the last flush,
    // arr = first cycle the core may see it (INF until memory has answered).
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        int          arr;
    } exp_t;
    // Memory-side view of outstanding fetches.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mem_t;

    exp_t exp_q[$];
    mem_t mem_q[$];

    int n_total = 0;
    int n_pass  = 0;
    int tput    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Stimulus + memory model + fetch-side reference.
    initial begin : stim
        logic [31:0] model_pc;
        int          last_due;
        int          c;
        int          lat;
        int          stale_cnt;
        bit          resp;
        bit          req_exp;
        bit          found;
        mem_t        m;
        exp_t        e;
        int          due;

        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        model_pc = RESET_PC; last_due = 0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_req", {31'd0, imem_req}, 32'd0);
        check("reset_addr", imem_addr, RESET_PC);

        while (cyc < NCYC) begin
            @(negedge clk);
            c = cyc;
            if (c == 1500) begin
                // Asynchronous reset mid-stream, entries queued behind a stalled core.
                rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0;
                #1;
                check("async_rst_req",   {31'd0, imem_req},    32'd0);
                check("async_rst_valid", {31'd0, instr_valid}, 32'd0);
                check("async_rst_addr",  imem_addr, RESET_PC);
                check("async_rst_instr", instr, NOP);
                mem_q.delete(); exp_q.delete();
                model_pc = RESET_PC; last_due = 0;
                continue;
            end
            rst_n = 1'b1;

            if ((c >= 200 && c < 230) || (c >= 1490 && c < 1500)) instr_ready = 1'b0;
            else if (c < 260 || (c >= 400 && c < 420))            instr_ready = 1'b1;
            else instr_ready = ($urandom_range(0, 9) < 7);

            if (c < 300 || (c >= 400 && c < 420)) imem_gnt = 1'b1;
            else imem_gnt = ($urandom_range(0, 9) < 7);

            if (c < 260 || (c >= 400 && c < 420)) lat = 1;
            else if (c < 300)                     lat = 3;
            else                                  lat = $urandom_range(1, 3);

            redirect = 1'b0;
            if (c == 300) begin
                redirect = 1'b1; redirect_pc = 32'h0000_0203;
            end else if (c == 400) begin
                redirect = 1'b1; redirect_pc = 32'hFFFF_FFF4;
            end else if (c >= 420 && $urandom_range(0, 29) == 0) begin
                redirect = 1'b1;
                redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                           : 32'($urandom_range(0, 'h3FF));
            end

            resp = (mem_q.size() > 0) && (mem_q[0].due <= c);
            imem_rvalid = resp;
            imem_rdata  = resp ? (mem_q[0].addr ^ KEY) : 32'($urandom);

            #1;
            stale_cnt = 0;
            foreach (mem_q[i]) if (mem_q[i].stale) stale_cnt++;
            req_exp = !redirect && (exp_q.size() < DEPTH) && (stale_cnt == 0);
            check("imem_req", {31'd0, imem_req}, {31'd0, req_exp});
            if (imem_req) check("imem_addr", imem_addr, model_pc);

            if (imem_req && imem_gnt) begin
                e.pc = model_pc; e.ins = model_pc ^ KEY; e.arr = INF;
                exp_q.push_back(e);
                due = (c + lat > last_due + 1) ? c + lat : last_due + 1;
                m.addr = imem_addr; m.due = due; m.stale = 1'b0;
                mem_q.push_back(m);
                last_due = due;
                model_pc = model_pc + 32'd4;
            end

            if (resp) begin
                m = mem_q.pop_front();
                if (!redirect && !m.stale) begin
                    found = 1'b0;
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (!found && exp_q[i].arr == INF) begin
                            exp_q[i].arr = c + 1;
                            found = 1'b1;
                        end
                    end
                    if (!found) begin
                        n_total++;
                        $display("FAIL resp_match: got response with no pending fetch expected none (cycle %0d)", c);
                    end
                end
            end

            if (redirect) begin
                foreach (mem_q[i]) mem_q[i].stale = 1'b1;
                exp_q.delete();
                model_pc = {redirect_pc[31:2], 2'b00};
            end
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Monitor: compares what the core sees against the expected stream.
    initial begin : mon
        bit   vexp;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            vexp = (exp_q.size() > 0) && (exp_q[0].arr <= cyc);
            if (!redirect) check("instr_valid", {31'd0, instr_valid}, {31'd0, vexp});
            if (!instr_valid) begin
                check("idle_instr", instr, NOP);
                check("idle_pc",    instr_pc, 32'd0);
            end
            if (rst_n && instr_valid && instr_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL pop_empty: got pc %h expected no instruction (cycle %0d)", instr_pc, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", instr_pc, e.pc);
                    check("instr",    instr,    e.ins);
                end
                if (cyc >= 20 && cyc < 200) tput++;
            end
            if (cyc == 200) check("throughput", 32'(tput), 32'd180);
        end
    end

endmodule
